// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command-driven sequencer for the 4-bit universal shift register
module shift_sequencer #(
    parameter int CW = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          CmdValid,
    output logic          CmdReady,
    input  logic [2:0]    CmdOp,
    input  logic [CW-1:0] CmdCount,
    input  logic          CmdLoad,
    input  logic [0:3]    CmdData,
    output logic [2:0]    S,
    output logic [0:3]    L,
    input  logic [0:3]    Q,
    output logic          Busy,
    output logic          Done,
    output logic [0:3]    Result
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b111;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_q, load_d;
    logic [0:3]    data_q, data_d;
    logic [2:0]    s_q, s_d;
    logic [0:3]    l_q, l_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [0:3]    result_q, result_d;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        load_d   = load_q;
        data_d   = data_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (CmdValid && ready_q) begin
                    op_d   = CmdOp;
                    cnt_d  = CmdCount;
                    load_d = CmdLoad;
                    data_d = CmdData;
                    if (CmdLoad)
                        state_d = ST_LOAD;
                    else if (CmdCount != '0 && CmdOp != OP_LOAD)
                        state_d = ST_SHIFT;
                    else
                        state_d = ST_CAPTURE;
                end
            end
            ST_LOAD: begin
                if (cnt_q != '0 && op_q != OP_LOAD)
                    state_d = ST_SHIFT;
                else
                    state_d = ST_CAPTURE;
            end
            ST_SHIFT: begin
                // Counter holds the number of SHIFT cycles still to run, including this one.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                result_d = Q;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        case (state_d)
            ST_LOAD:  s_d = OP_LOAD;
            ST_SHIFT: s_d = op_d;
            default:  s_d = OP_HOLD;
        endcase
        l_d     = (state_d == ST_LOAD && load_d) ? data_d : 4'b0000;
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            load_q   <= 1'b0;
            data_q   <= '0;
            s_q      <= OP_HOLD;
            l_q      <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            data_q   <= data_d;
            s_q      <= s_d;
            l_q      <= l_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign CmdReady = ready_q;
    assign S        = s_q;
    assign L        = l_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Result   = result_q;

endmodule
